// File: rtl/uart_cmd_responder.sv
// +----------------------------------------------------------------------+
// | uart_cmd_responder: UART byte-frame command parser driving a small   |
// | 8-bit register bus ('W' addr data / 'R' addr).  Revision: 1.0        |
// +----------------------------------------------------------------------+
`default_nettype none

module uart_cmd_responder #(
   parameter int NREG    = 16,
   parameter int TIMEOUT = 100000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rx_empty,
   input  logic [7:0] r_data,
   output logic       rd_uart,
   input  logic       tx_full,
   output logic       wr_uart,
   output logic [7:0] w_data,
   output logic [7:0] reg_addr,
   output logic [7:0] reg_wdata,
   output logic       reg_we,
   input  logic [7:0] reg_rdata,
   output logic       frame_err
);

   localparam int             CW       = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT - 1);
   localparam logic [8:0]     NREG_LIM = 9'(NREG);
   localparam logic [7:0]     OP_WRITE = 8'h57;
   localparam logic [7:0]     OP_READ  = 8'h52;
   localparam logic [7:0]     RESP_BAD = 8'h3F;
   localparam logic [7:0]     RESP_ERR = 8'h45;
   localparam logic [7:0]     RESP_OK  = 8'h4B;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      GET_ADDR = 3'd1,
      GET_DATA = 3'd2,
      EXEC     = 3'd3,
      SEND     = 3'd4
   } state_t;

   state_t          state;
   logic [CW-1:0]   cnt;
   logic [7:0]      opcode;
   logic [7:0]      addr;
   logic [7:0]      resp;
   logic            receiving;
   logic            pop;
   logic            addr_ok;

   // Pop and push strobes are combinational so the FIFO head is consumed in
   // the very cycle it is captured, and a push fires as soon as tx_full drops.
   assign receiving = (state == IDLE) || (state == GET_ADDR) || (state == GET_DATA);
   assign pop       = receiving && !rx_empty && !reset;
   assign rd_uart   = pop;
   assign wr_uart   = (state == SEND) && !tx_full && !reset;
   assign w_data    = resp;
   assign addr_ok   = {1'b0, addr} < NREG_LIM;

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         cnt       <= '0;
         opcode    <= '0;
         addr      <= '0;
         resp      <= '0;
         reg_addr  <= '0;
         reg_wdata <= '0;
         reg_we    <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         reg_we    <= 1'b0;
         frame_err <= 1'b0;
         unique case (state)
            IDLE: begin
               cnt <= '0;
               if (pop) begin
                  opcode <= r_data;
                  if (r_data == OP_WRITE || r_data == OP_READ) begin
                     state <= GET_ADDR;
                  end else begin
                     resp      <= RESP_BAD;
                     frame_err <= 1'b1;
                     state     <= SEND;
                  end
               end
            end
            GET_ADDR, GET_DATA: begin
               if (pop) begin
                  cnt <= '0;
                  if (state == GET_ADDR) begin
                     addr <= r_data;
                     if (opcode == OP_WRITE) begin
                        state <= GET_DATA;
                     end else begin
                        reg_addr <= r_data;
                        state    <= EXEC;
                     end
                  end else begin
                     // Bus outputs are loaded on entry to EXEC so they are
                     // valid during EXEC and held unchanged afterwards.
                     reg_addr  <= addr;
                     reg_wdata <= r_data;
                     reg_we    <= addr_ok;
                     state     <= EXEC;
                  end
               end else if (cnt == CNT_LAST) begin
                  cnt       <= '0;
                  frame_err <= 1'b1;
                  state     <= IDLE;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            EXEC: begin
               if (!addr_ok) begin
                  resp      <= RESP_ERR;
                  frame_err <= 1'b1;
               end else if (opcode == OP_WRITE) begin
                  resp <= RESP_OK;
               end else begin
                  resp <= reg_rdata;
               end
               state <= SEND;
            end
            SEND: begin
               if (!tx_full) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: doc/uart_cmd_responder.md
UART_CMD_RESPONDER -- requirements
Module: uart_cmd_responder

Interface
REQ-001 SHALL have parameter NREG, default 16, giving the number of addressable 8-bit registers (1..256).
REQ-002 SHALL have parameter TIMEOUT, default 100000, giving the maximum idle clk cycles allowed between bytes of one frame.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port rx_empty  input  1  high when the UART receive FIFO holds no byte.
REQ-006 SHALL have port r_data  input  8  head byte of the receive FIFO, valid while rx_empty=0.
REQ-007 SHALL have port rd_uart  output  1  one-cycle pop strobe to the receive FIFO.
REQ-008 SHALL have port tx_full  input  1  high when the UART transmit FIFO cannot accept a byte.
REQ-009 SHALL have port wr_uart  output  1  one-cycle push strobe to the transmit FIFO.
REQ-010 SHALL have port w_data  output  8  byte pushed when wr_uart=1.
REQ-011 SHALL have port reg_addr  output  8  register-bus address.
REQ-012 SHALL have port reg_wdata  output  8  register-bus write data.
REQ-013 SHALL have port reg_we  output  1  one-cycle register write strobe.
REQ-014 SHALL have port reg_rdata  input  8  register-bus read data, combinational from reg_addr.
REQ-015 SHALL have port frame_err  output  1  one-cycle pulse on an aborted or rejected frame.

Function
REQ-016 SHALL accept frames: write = 0x57 ('W'), addr, data; read = 0x52 ('R'), addr.
REQ-017 SHALL implement states IDLE, GET_ADDR, GET_DATA, EXEC, SEND.
REQ-018 SHALL assert rd_uart exactly in cycles where the state is IDLE, GET_ADDR or GET_DATA and rx_empty=0, and SHALL capture r_data in that same cycle.
REQ-019 SHALL never assert rd_uart in EXEC or SEND; the receive FIFO backpressures the sender.
REQ-020 IDLE: on a popped byte, SHALL go to GET_ADDR for 0x57 or 0x52; any other byte SHALL load response 0x3F ('?'), pulse frame_err and go to SEND.
REQ-021 GET_ADDR: on a popped byte, SHALL latch the address, then go to GET_DATA for a write or EXEC for a read.
REQ-022 GET_DATA: on a popped byte, SHALL latch the data and go to EXEC.
REQ-023 EXEC (one cycle): if addr >= NREG, SHALL load response 0x45 ('E') and pulse frame_err with reg_we=0; otherwise, for a write, SHALL assert reg_we with reg_addr and reg_wdata and load response 0x4B ('K'); for a read, SHALL drive reg_addr and load reg_rdata as the response. It SHALL then go to SEND.
REQ-024 SEND: SHALL assert wr_uart with w_data equal to the response in the first cycle tx_full=0, then go to IDLE; while tx_full=1, it SHALL hold state with wr_uart=0.
REQ-025 Latency: reg_we SHALL be asserted exactly 1 cycle after the data-byte pop; wr_uart SHALL be asserted no earlier than 2 cycles after the last frame byte pop (when tx_full=0).
REQ-026 An inter-byte counter SHALL clear on every pop and in IDLE, and SHALL increment each cycle in GET_ADDR/GET_DATA without a pop.
REQ-027 When that counter reaches TIMEOUT-1, the block SHALL return to IDLE, pulse frame_err, and send no response.
REQ-028 The counter width SHALL be $clog2(TIMEOUT+1) and SHALL not wrap.
REQ-029 reg_addr and reg_wdata SHALL hold their last values outside EXEC.
REQ-030 reg_we, rd_uart and wr_uart SHALL each be high for at most 1 cycle per event, and never concurrently with reset=1.

Reset
REQ-031 When reset=1 at a clock edge, SHALL enter IDLE and clear the timeout counter, latched opcode, address, data and response to 0.
REQ-032 During reset, reg_addr and reg_wdata SHALL be 0 and reg_we, rd_uart, wr_uart and frame_err SHALL be 0.
REQ-033 A reset mid-frame SHALL discard the partial frame with no response and no register write.

Verification
REQ-034 Write: rx bytes 0x57,0x03,0xA5 with tx_full=0 -> one reg_we with reg_addr=0x03, reg_wdata=0xA5; one wr_uart with w_data=0x4B.
REQ-035 Read: reg_rdata model returns 0x5C at addr 0x07; rx 0x52,0x07 -> wr_uart with w_data=0x5C; reg_we stays 0.
REQ-036 Errors: rx 0x41 -> w_data=0x3F plus frame_err; rx 0x57,0x20,0x11 (NREG=16) -> w_data=0x45, frame_err, no reg_we.
REQ-037 Backpressure: complete a read with tx_full=1 held for 50 cycles -> wr_uart=0 and rd_uart=0 throughout; wr_uart fires in the first cycle after tx_full falls.
REQ-038 Timeout (TIMEOUT=20): rx 0x57,0x02 then nothing for 20 cycles -> frame_err pulses once with no wr_uart; a following 0x52,0x02 is answered normally.
REQ-039 Reset mid-frame: rx 0x57,0x01, then reset=1 for 1 cycle, then 0x52,0x01 -> no reg_we; a single read response is produced.
